// File: rtl/ibex_prefetch_buffer_mq.sv
// ---------------------------------------------------------------------------
// ibex_prefetch_buffer_mq
//
// Instruction prefetch buffer with multiple outstanding bus requests.
// Fetches sequential words from the address given on the last branch and
// buffers the returned words in a small FIFO. FIFO space is reserved when a
// request is issued, so a response always has somewhere to land.
//
// Parameters
//   NUM_REQS    : maximum granted-but-unanswered bus requests (1..8)
//   FIFO_DEPTH  : fetched-word storage entries (NUM_REQS..16)
//   STOP_ON_ERR : stop issuing after buffering an errored word until a branch
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_i                 : fetch enable
//   branch_i, addr_i      : redirect fetch to {addr_i[31:2], 2'b00}
//   valid_o, ready_i      : consumer handshake for the FIFO head
//   rdata_o, addr_o, err_o: head word, its word address and bus error flag
//   instr_*               : request/grant + in-order response bus
//   busy_o                : request pending or responses outstanding
//   outstanding_o         : granted requests not yet answered
//   discard_cnt_o         : saturating count of dropped responses (only when
//                           IBEX_PREFETCH_DISCARD_CNT_EN is defined)
//
// Optional feature macro: IBEX_PREFETCH_DISCARD_CNT_EN
// ---------------------------------------------------------------------------
module ibex_prefetch_buffer_mq #(
    parameter int unsigned NUM_REQS    = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    input  logic                          branch_i,
    input  logic [31:0]                   addr_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [31:0]                   rdata_o,
    output logic [31:0]                   addr_o,
    output logic                          err_o,
    output logic                          instr_req_o,
    input  logic                          instr_gnt_i,
    output logic [31:0]                   instr_addr_o,
    input  logic [31:0]                   instr_rdata_i,
    input  logic                          instr_err_i,
    input  logic                          instr_rvalid_i,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQS+1)-1:0] outstanding_o
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
    ,
    output logic [15:0]                   discard_cnt_o
`endif
);

    localparam int unsigned OW  = $clog2(NUM_REQS + 1);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned QPW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int unsigned SW  = ((CW > OW) ? CW : OW) + 1;

    // Fetch / request state
    logic              fetch_ok_q;      // a branch has been seen since reset
    logic [31:0]       fetch_addr_q;    // next sequential fetch address
    logic              req_held_q;      // request on the bus awaiting grant
    logic [31:0]       held_addr_q;
    logic              held_disc_q;     // held request was overtaken by a branch
    logic              err_halt_q;

    // In-order tracker of granted requests: address and discard flag
    logic [OW-1:0]       outstanding_q;
    logic [QPW-1:0]      oq_wptr_q;
    logic [QPW-1:0]      oq_rptr_q;
    logic [31:0]         oq_addr_q [NUM_REQS];
    logic [NUM_REQS-1:0] oq_disc_q;
    logic [NUM_REQS-1:0] oq_disc_d;

    // Fetched-word FIFO
    logic [31:0]           fifo_data_q [FIFO_DEPTH];
    logic [31:0]           fifo_addr_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_err_q;
    logic [FPW-1:0]        fifo_wptr_q;
    logic [FPW-1:0]        fifo_rptr_q;
    logic [CW-1:0]         fifo_cnt_q;

    logic [31:0] branch_addr;
    logic [31:0] issue_addr;
    logic        space_ok;
    logic        halted;
    logic        new_req;
    logic        grant;
    logic        grant_disc;
    logic        rsp_valid;
    logic        head_disc;
    logic        rsp_push;
    logic        rsp_drop;
    logic        pop;
    logic        unused_addr_lsb;

    function automatic logic [FPW-1:0] fifo_ptr_inc(input logic [FPW-1:0] p);
        if (p == FPW'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + FPW'(1);
    endfunction

    function automatic logic [QPW-1:0] oq_ptr_inc(input logic [QPW-1:0] p);
        if (p == QPW'(NUM_REQS - 1)) begin
            return '0;
        end
        return p + QPW'(1);
    endfunction

    assign unused_addr_lsb = ^addr_i[1:0];

    assign branch_addr = {addr_i[31:2], 2'b00};
    assign issue_addr  = branch_i ? branch_addr : fetch_addr_q;

    // Outstanding requests (including ones that will be discarded) count
    // against FIFO space; a branch empties the FIFO so space is guaranteed.
    assign space_ok = (SW'(fifo_cnt_q) + SW'(outstanding_q)) < SW'(FIFO_DEPTH);
    assign halted   = err_halt_q & ~branch_i;

    // A fresh request is only started when none is held, which keeps the
    // held request's address stable on the bus until it is granted.
    assign new_req = ~req_held_q & req_i & (fetch_ok_q | branch_i) &
                     (outstanding_q < OW'(NUM_REQS)) & (space_ok | branch_i) & ~halted;

    assign instr_req_o  = req_held_q | new_req;
    assign instr_addr_o = req_held_q ? held_addr_q : issue_addr;
    assign grant        = instr_req_o & instr_gnt_i;
    assign grant_disc   = req_held_q & (held_disc_q | branch_i);

    // Responses with nothing outstanding are stray (e.g. pre-reset) and ignored.
    assign rsp_valid = instr_rvalid_i & (outstanding_q != '0);
    assign head_disc = oq_disc_q[oq_rptr_q];
    assign rsp_push  = rsp_valid & ~head_disc & ~branch_i;
    assign rsp_drop  = rsp_valid & (head_disc | branch_i);

    assign valid_o = (fifo_cnt_q != '0);
    assign pop     = valid_o & ready_i & ~branch_i;
    assign rdata_o = fifo_data_q[fifo_rptr_q];
    assign addr_o  = fifo_addr_q[fifo_rptr_q];
    assign err_o   = valid_o & fifo_err_q[fifo_rptr_q];

    assign busy_o        = (outstanding_q != '0) | instr_req_o;
    assign outstanding_o = outstanding_q;

    // A slot being written by this cycle's grant takes the grant's flag;
    // every other slot becomes discarded on a branch.
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_oq_disc
        assign oq_disc_d[gi] = (grant && (oq_wptr_q == QPW'(gi))) ? grant_disc
                                                                  : (oq_disc_q[gi] | branch_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_ok_q    <= 1'b0;
            fetch_addr_q  <= '0;
            req_held_q    <= 1'b0;
            held_addr_q   <= '0;
            held_disc_q   <= 1'b0;
            err_halt_q    <= 1'b0;
            outstanding_q <= '0;
            oq_wptr_q     <= '0;
            oq_rptr_q     <= '0;
            oq_disc_q     <= '0;
            fifo_wptr_q   <= '0;
            fifo_rptr_q   <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            fetch_ok_q <= fetch_ok_q | branch_i;

            if (new_req) begin
                fetch_addr_q <= issue_addr + 32'd4;
            end else if (branch_i) begin
                fetch_addr_q <= branch_addr;
            end

            req_held_q <= instr_req_o & ~instr_gnt_i;
            if (instr_req_o) begin
                held_addr_q <= instr_addr_o;
            end
            held_disc_q <= grant_disc;

            outstanding_q <= outstanding_q + OW'(grant) - OW'(rsp_valid);
            if (grant) begin
                oq_wptr_q <= oq_ptr_inc(oq_wptr_q);
            end
            if (rsp_valid) begin
                oq_rptr_q <= oq_ptr_inc(oq_rptr_q);
            end
            oq_disc_q <= oq_disc_d;

            if (branch_i) begin
                err_halt_q <= 1'b0;
            end else if (rsp_push && instr_err_i && STOP_ON_ERR) begin
                err_halt_q <= 1'b1;
            end

            if (branch_i) begin
                fifo_wptr_q <= '0;
                fifo_rptr_q <= '0;
                fifo_cnt_q  <= '0;
            end else begin
                if (rsp_push) begin
                    fifo_wptr_q <= fifo_ptr_inc(fifo_wptr_q);
                end
                if (pop) begin
                    fifo_rptr_q <= fifo_ptr_inc(fifo_rptr_q);
                end
                fifo_cnt_q <= fifo_cnt_q + CW'(rsp_push) - CW'(pop);
            end
        end
    end

    // Storage arrays carry no reset; their contents are qualified by the
    // pointers and counts above.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            oq_addr_q[oq_wptr_q] <= instr_addr_o;
        end
        if (rsp_push) begin
            fifo_data_q[fifo_wptr_q] <= instr_rdata_i;
            fifo_addr_q[fifo_wptr_q] <= oq_addr_q[oq_rptr_q];
            fifo_err_q[fifo_wptr_q]  <= instr_err_i;
        end
    end

`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
    logic [15:0] discard_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            discard_cnt_q <= '0;
        end else if (rsp_drop && (discard_cnt_q != 16'hFFFF)) begin
            discard_cnt_q <= discard_cnt_q + 16'd1;
        end
    end

    assign discard_cnt_o = discard_cnt_q;
`else
    logic unused_rsp_drop;
    assign unused_rsp_drop = rsp_drop;
`endif

endmodule

// File: tb/tb_ibex_prefetch_buffer_mq.sv
// ---------------------------------------------------------------------------
// tb_ibex_prefetch_buffer_mq
//
// Directed bench for ibex_prefetch_buffer_mq (default parameters). A small
// in-order bus responder returns ~address as data, one cycle after grant,
// and flags an error for one selectable address.
// ---------------------------------------------------------------------------
module tb_ibex_prefetch_buffer_mq;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        instr_rvalid_i;
    logic        busy_o;
    logic [1:0]  outstanding_o;
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
    logic [15:0] discard_cnt_o;
`endif

    always #5 clk = ~clk;

    ibex_prefetch_buffer_mq #(
        .NUM_REQS   (2),
        .FIFO_DEPTH (4),
        .STOP_ON_ERR(1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .addr_i        (addr_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .rdata_o       (rdata_o),
        .addr_o        (addr_o),
        .err_o         (err_o),
        .instr_req_o   (instr_req_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_addr_o  (instr_addr_o),
        .instr_rdata_i (instr_rdata_i),
        .instr_err_i   (instr_err_i),
        .instr_rvalid_i(instr_rvalid_i),
        .busy_o        (busy_o),
        .outstanding_o (outstanding_o)
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
        ,
        .discard_cnt_o (discard_cnt_o)
`endif
    );

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;
    int unsigned fail_cnt  = 0;

    logic        gnt_en;
    logic        rsp_en;
    logic [31:0] err_addr;
    logic [31:0] pend_q[$];
    logic [31:0] grant_log[$];
    logic [31:0] pop_addr[$];
    logic [31:0] pop_data[$];
    logic        pop_err[$];
    int          req_cycles;
    int          max_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_addr_at(input int i);
        return (i < pop_addr.size()) ? pop_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pop_data_at(input int i);
        return (i < pop_data.size()) ? pop_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pop_err_at(input int i);
        return (i < pop_err.size()) ? 32'(pop_err[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] grant_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_logs();
        grant_log.delete();
        pop_addr.delete();
        pop_data.delete();
        pop_err.delete();
        req_cycles = 0;
        max_out    = 0;
    endtask

    // One clock cycle: drive bus inputs, sample away from the edge, then
    // update the responder and the logs with what happened at the edge.
    // Entered and left at a falling edge.
    task automatic tick();
        logic        g;
        logic        p;
        logic        r;
        logic        pe;
        logic [31:0] ga;
        logic [31:0] pa;
        logic [31:0] pd;
        instr_gnt_i = gnt_en;
        if (rsp_en && (pend_q.size() != 0)) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = ~pend_q[0];
            instr_err_i    = (pend_q[0] == err_addr);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
            instr_err_i    = 1'b0;
        end
        #1;
        g  = instr_req_o & instr_gnt_i;
        ga = instr_addr_o;
        p  = valid_o & ready_i & ~branch_i & ~rst_i;
        pa = addr_o;
        pd = rdata_o;
        pe = err_o;
        r  = instr_rvalid_i;
        if (instr_req_o) req_cycles++;
        if (int'(outstanding_o) > max_out) max_out = int'(outstanding_o);
        @(posedge clk);
        if (r) void'(pend_q.pop_front());
        if (g) begin
            pend_q.push_back(ga);
            grant_log.push_back(ga);
        end
        if (p) begin
            pop_addr.push_back(pa);
            pop_data.push_back(pd);
            pop_err.push_back(pe);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        req_i    = 1'b0;
        branch_i = 1'b0;
        ready_i  = 1'b1;
        gnt_en   = 1'b1;
        rsp_en   = 1'b1;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        rst_i          = 1'b1;
        req_i          = 1'b0;
        branch_i       = 1'b0;
        addr_i         = '0;
        ready_i        = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rdata_i  = '0;
        instr_err_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        gnt_en         = 1'b0;
        rsp_en         = 1'b1;
        err_addr       = 32'h0000_0001;
        clear_logs();

        // ---------------- reset state ----------------
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        rst_i = 1'b0;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_req", 32'(instr_req_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_outstanding", 32'(outstanding_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
        check("rst_discard_cnt", 32'(discard_cnt_o), 32'd0);
`endif
        req_i = 1'b1;
        #1;
        check("no_fetch_before_branch", 32'(instr_req_o), 32'd0);
        tick();

        // ---------------- streaming from 0x100 ----------------
        clear_logs();
        gnt_en   = 1'b1;
        rsp_en   = 1'b1;
        ready_i  = 1'b1;
        branch_i = 1'b1;
        addr_i   = 32'h0000_0100;
        tick();
        branch_i = 1'b0;
        check("stream_out_after_grant", 32'(outstanding_o), 32'd1);
        check("stream_valid_latency0", 32'(valid_o), 32'd0);
        tick();
        check("stream_valid_latency1", 32'(valid_o), 32'd1);
        check("stream_head_addr", addr_o, 32'h0000_0100);
        check("stream_head_data", rdata_o, 32'hFFFF_FEFF);
        for (int i = 0; i < 6; i++) tick();
        check("stream_pop0", pop_addr_at(0), 32'h0000_0100);
        check("stream_pop1", pop_addr_at(1), 32'h0000_0104);
        check("stream_pop2", pop_addr_at(2), 32'h0000_0108);
        check("stream_data2", pop_data_at(2), 32'hFFFF_FEF7);
        check("stream_max_out", 32'(max_out <= 2), 32'd1);
        drain();
        check("stream_idle_busy", 32'(busy_o), 32'd0);

        // ---------------- backpressure fills FIFO ----------------
        clear_logs();
        ready_i  = 1'b0;
        req_i    = 1'b1;
        branch_i = 1'b1;
        addr_i   = 32'h0000_0400;
        tick();
        branch_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("full_grants", 32'(grant_log.size()), 32'd4);
        check("full_req_cycles", 32'(req_cycles), 32'd4);
        check("full_req_low", 32'(instr_req_o), 32'd0);
        check("full_valid", 32'(valid_o), 32'd1);
        check("full_head_addr", addr_o, 32'h0000_0400);
        check("full_outstanding", 32'(outstanding_o), 32'd0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("full_req_after_pop", 32'(instr_req_o), 32'd1);
        check("full_addr_after_pop", instr_addr_o, 32'h0000_0410);
        drain();

        // ---------------- branch with two outstanding ----------------
        clear_logs();
        gnt_en   = 1'b1;
        rsp_en   = 1'b0;
        ready_i  = 1'b1;
        req_i    = 1'b1;
        branch_i = 1'b1;
        addr_i   = 32'h0000_0500;
        tick();
        branch_i = 1'b0;
        tick();
        check("disc_outstanding", 32'(outstanding_o), 32'd2);
        check("disc_req_at_limit", 32'(instr_req_o), 32'd0);
        branch_i = 1'b1;
        addr_i   = 32'h0000_0200;
        rsp_en   = 1'b1;
        tick();
        branch_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("disc_first_pop", pop_addr_at(0), 32'h0000_0200);
        check("disc_second_pop", pop_addr_at(1), 32'h0000_0204);
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
        check("disc_cnt_2", 32'(discard_cnt_o), 32'd2);
`endif
        drain();

        // ---------------- branch while request held ----------------
        clear_logs();
        gnt_en   = 1'b0;
        rsp_en   = 1'b1;
        ready_i  = 1'b1;
        req_i    = 1'b1;
        branch_i = 1'b1;
        addr_i   = 32'h0000_0600;
        tick();
        branch_i = 1'b0;
        check("held_req", 32'(instr_req_o), 32'd1);
        check("held_addr0", instr_addr_o, 32'h0000_0600);
        branch_i = 1'b1;
        addr_i   = 32'h0000_0300;
        #1;
        check("held_addr_on_branch", instr_addr_o, 32'h0000_0600);
        tick();
        branch_i = 1'b0;
        check("held_addr_after_branch", instr_addr_o, 32'h0000_0600);
        tick();
        gnt_en = 1'b1;
        tick();
        check("held_next_addr", instr_addr_o, 32'h0000_0300);
        for (int i = 0; i < 6; i++) tick();
        check("held_grant0", grant_at(0), 32'h0000_0600);
        check("held_grant1", grant_at(1), 32'h0000_0300);
        check("held_first_pop", pop_addr_at(0), 32'h0000_0300);
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
        check("held_disc_cnt_3", 32'(discard_cnt_o), 32'd3);
`endif
        drain();

        // ---------------- bus error halts prefetch ----------------
        clear_logs();
        err_addr = 32'h0000_0708;
        gnt_en   = 1'b1;
        rsp_en   = 1'b1;
        ready_i  = 1'b1;
        req_i    = 1'b1;
        branch_i = 1'b1;
        addr_i   = 32'h0000_0700;
        tick();
        branch_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("err_grants", 32'(grant_log.size()), 32'd4);
        check("err_req_halted", 32'(instr_req_o), 32'd0);
        check("err_pop_addr2", pop_addr_at(2), 32'h0000_0708);
        check("err_flag2", pop_err_at(2), 32'd1);
        check("err_flag1", pop_err_at(1), 32'd0);
        branch_i = 1'b1;
        addr_i   = 32'h0000_0800;
        #1;
        check("err_req_on_branch", 32'(instr_req_o), 32'd1);
        check("err_addr_on_branch", instr_addr_o, 32'h0000_0800);
        tick();
        err_addr = 32'h0000_0001;
        drain();

        // ---------------- address wrap, then reset mid-stream ----------------
        clear_logs();
        gnt_en   = 1'b1;
        rsp_en   = 1'b1;
        ready_i  = 1'b1;
        req_i    = 1'b1;
        branch_i = 1'b1;
        addr_i   = 32'hFFFF_FFFB;
        tick();
        branch_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("wrap_pop0", pop_addr_at(0), 32'hFFFF_FFF8);
        check("wrap_pop1", pop_addr_at(1), 32'hFFFF_FFFC);
        check("wrap_pop2", pop_addr_at(2), 32'h0000_0000);
        ready_i = 1'b0;
        rsp_en  = 1'b0;
        tick();
        tick();
        check("mid_valid_before_rst", 32'(valid_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_outstanding", 32'(outstanding_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
`ifdef IBEX_PREFETCH_DISCARD_CNT_EN
        check("mid_rst_disc_cnt", 32'(discard_cnt_o), 32'd0);
`endif
        rsp_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("late_rvalid_valid", 32'(valid_o), 32'd0);
        check("late_rvalid_outstanding", 32'(outstanding_o), 32'd0);
        pend_q.delete();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ibex_prefetch_buffer_mq.md
IBEX_PREFETCH_BUFFER_MQ -- requirements
Module: ibex_prefetch_buffer_mq

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2, max bus requests outstanding (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, fetched-word storage entries (>= NUM_REQS, <= 16).
REQ-003 SHALL have parameter STOP_ON_ERR, default 1, halt prefetch after a bus error until next branch.
REQ-004 SHALL have ports: clk_i  in  1  sole clock; rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: req_i in 1 fetch enable; branch_i in 1 redirect; addr_i in 32 redirect target.
REQ-006 SHALL have ports: valid_o out 1; ready_i in 1; rdata_o out 32; addr_o out 32 word address of rdata_o; err_o out 1.
REQ-007 SHALL have ports: instr_req_o out 1; instr_gnt_i in 1; instr_addr_o out 32; instr_rdata_i in 32; instr_err_i in 1; instr_rvalid_i in 1.
REQ-008 SHALL have ports: busy_o out 1; outstanding_o out $clog2(NUM_REQS+1) count of granted, unanswered requests.

Function
REQ-009 SHALL issue a new request when req_i, outstanding < NUM_REQS, (FIFO occupancy + outstanding < FIFO_DEPTH or branch_i), and not error-halted.
REQ-010 SHALL hold instr_req_o and instr_addr_o stable from first assertion until instr_gnt_i, including across branch_i.
REQ-011 SHALL drive instr_addr_o[1:0] = 2'b00; next fetch address = previous + 4, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-012 SHALL on branch_i load fetch address from {addr_i[31:2],2'b00}, driving addr_i directly on the bus that cycle if no request is held.
REQ-013 SHALL on branch_i mark every outstanding request, and any held-but-ungranted request, as discard; discarded responses never enter the FIFO.
REQ-014 SHALL assume in-order responses; rvalid with outstanding_o == 0 SHALL be ignored.
REQ-015 SHALL push {instr_rdata_i, instr_err_i, address} on non-discarded instr_rvalid_i; valid_o rises the following cycle (1-cycle latency, no bypass).
REQ-016 SHALL pop the head entry when valid_o & ready_i; valid_o = FIFO non-empty.
REQ-017 SHALL clear the FIFO on branch_i; a pop or push in the same cycle is cancelled.
REQ-018 SHALL, with STOP_ON_ERR=1, stop issuing new requests after pushing an entry with err set; only branch_i clears the halt.
REQ-019 SHALL never overflow: push always lands in space reserved at grant time.
REQ-020 SHALL drive busy_o = (outstanding_o != 0) | instr_req_o.
REQ-021 SHALL update outstanding_o by +1 on grant, -1 on rvalid, unchanged when both occur.

Reset
REQ-022 SHALL, while rst_i high at a clk_i edge, clear FIFO, outstanding count, discard flags, held request, error halt; reset overrides branch_i.
REQ-023 SHALL present after reset: valid_o 0, instr_req_o 0, busy_o 0, outstanding_o 0, err_o 0, discard_cnt_o 0.
REQ-024 SHALL ignore responses arriving after reset for requests granted before it.
REQ-025 SHALL require a branch_i after reset before fetching; fetch address is undefined until then.

Configuration
REQ-026 SHALL with IBEX_PREFETCH_DISCARD_CNT_EN defined add port discard_cnt_o out 16, a saturating count (sticks at 0xFFFF) of discarded responses; without it the port and counter SHALL not exist and behaviour is otherwise identical.

Verification
REQ-027 SHALL cover: branch to 0x100, gnt every cycle, rvalid 1 cycle later, ready_i=1 -> addr_o 0x100,0x104,0x108 in order, outstanding_o never > NUM_REQS.
REQ-028 SHALL cover: ready_i=0, FIFO_DEPTH=4, NUM_REQS=2 -> exactly 4 requests issued then instr_req_o stays 0 until a pop.
REQ-029 SHALL cover: 2 outstanding, branch_i to 0x200 -> both responses dropped, first valid_o has addr_o 0x200; discard_cnt_o == 2 with macro.
REQ-030 SHALL cover: request held without gnt, branch_i to 0x300 -> instr_addr_o unchanged until gnt, response discarded, next request addr 0x300.
REQ-031 SHALL cover: response with instr_err_i=1, STOP_ON_ERR=1 -> err_o=1 on that entry, no further requests until branch_i.
REQ-032 SHALL cover: branch to 0xFFFFFFF8 -> addr_o 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; rst_i mid-stream -> valid_o 0 next cycle, late rvalid ignored.
